// File: rtl/salamander_romport_arbiter.sv
// salamander_romport_arbiter: round-robin share of one ROM read port between prog, data and sound requesters.
// Optional SALAMANDER_ROMARB_CACHE_EN adds a one-entry address tag per requester to skip repeat fetches.
module salamander_romport_arbiter #(
  parameter logic [18:0] PROG_BASE = 19'h00000,
  parameter logic [18:0] DATA_BASE = 19'h20000,
  parameter logic [18:0] SND_BASE  = 19'h40000
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_INITRST_n,
  input  logic [15:0] i_PROGROM_ADDR,
  input  logic        i_PROGROM_RDRQ,
  output logic [15:0] o_PROGROM_DATA,
  output logic        o_PROGROM_RDY,
  input  logic [16:0] i_DATAROM_ADDR,
  input  logic        i_DATAROM_RDRQ,
  output logic [15:0] o_DATAROM_DATA,
  output logic        o_DATAROM_RDY,
  input  logic [14:0] i_SNDROM_ADDR,
  input  logic        i_SNDROM_RDRQ,
  output logic [7:0]  o_SNDROM_DATA,
  output logic        o_SNDROM_RDY,
  output logic [18:0] o_MEM_ADDR,
  output logic        o_MEM_RD,
  input  logic        i_MEM_ACK,
  input  logic [15:0] i_MEM_DATA
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [2:0] rdrq, rq_q, rise, hit, fast, arm, clr, set, pend_q, pend_d, rdy_q, rdy_d;
  logic [2:0][16:0] cur, addr_q, addr_d;
  logic [1:0] gnt_q, gnt_d, c0, c1, c2, pick;
  logic live_q, live_d, sel_q, sel_d, mem_rd_q, mem_rd_d, ack, grant;
  logic [18:0] mem_addr_q, mem_addr_d, maddr;
  logic [15:0] pdata_q, pdata_d, ddata_q, ddata_d;
  logic [7:0] sdata_q, sdata_d;
  assign rdrq  = {i_SNDROM_RDRQ, i_DATAROM_RDRQ, i_PROGROM_RDRQ};
  assign cur   = {{2'b0, i_SNDROM_ADDR}, i_DATAROM_ADDR, {1'b0, i_PROGROM_ADDR}};
  assign rise  = rdrq & ~rq_q;
  assign arm   = rise & ~hit;
  assign ack   = state_q == BUSY && i_MEM_ACK;
  assign grant = state_q == IDLE && |pend_q;
  // gnt_q doubles as the last-grant pointer; search starts just after it
  assign c0    = gnt_q == 2'd2 ? 2'd0 : gnt_q + 2'd1;
  assign c1    = c0 == 2'd2 ? 2'd0 : c0 + 2'd1;
  assign c2    = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
  assign pick  = pend_q[c0] ? c0 : pend_q[c1] ? c1 : c2;
  assign maddr = pick == 2'd0 ? PROG_BASE + {2'b0, addr_q[0]} :
                 pick == 2'd1 ? DATA_BASE + {2'b0, addr_q[1]} : SND_BASE + {3'b0, addr_q[2][16:1]};
  always_comb begin
    state_d    = state_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    clr        = '0;
    set        = '0;
    live_d     = live_q & rdrq[gnt_q];
    if (grant) begin
      state_d    = BUSY;
      mem_rd_d   = 1'b1;
      mem_addr_d = maddr;
      gnt_d      = pick;
      sel_d      = addr_q[2][0];
      clr[pick]  = 1'b1;
      live_d     = rdrq[pick];
    end else if (ack) begin
      state_d    = IDLE;
      mem_rd_d   = 1'b0;
      set[gnt_q] = live_d;
    end
    for (int i = 0; i < 3; i++) addr_d[i] = arm[i] ? cur[i] : addr_q[i];
    pend_d  = (pend_q & ~clr) | arm;
    rdy_d   = rdrq & (rdy_q | set | fast);
    pdata_d = ack && gnt_q == 2'd0 ? i_MEM_DATA : pdata_q;
    ddata_d = ack && gnt_q == 2'd1 ? i_MEM_DATA : ddata_q;
    sdata_d = ack && gnt_q == 2'd2 ? (sel_q ? i_MEM_DATA[7:0] : i_MEM_DATA[15:8]) : sdata_q;
  end
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n)
    if (!i_EMU_INITRST_n) begin
      state_q    <= IDLE;
      rq_q       <= '0;
      pend_q     <= '0;
      rdy_q      <= '0;
      addr_q     <= '0;
      gnt_q      <= 2'd2;
      live_q     <= 1'b0;
      sel_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      pdata_q    <= '0;
      ddata_q    <= '0;
      sdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rq_q       <= rdrq;
      pend_q     <= pend_d;
      rdy_q      <= rdy_d;
      addr_q     <= addr_d;
      gnt_q      <= gnt_d;
      live_q     <= live_d;
      sel_q      <= sel_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      pdata_q    <= pdata_d;
      ddata_q    <= ddata_d;
      sdata_q    <= sdata_d;
    end
`ifdef SALAMANDER_ROMARB_CACHE_EN
  logic [2:0] tv_q, hit_q;
  logic [2:0][16:0] tag_q;
  logic [16:0] gaddr_q;
  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++) hit[i] = rise[i] & tv_q[i] & (tag_q[i] == cur[i]);
  end
  assign fast = hit_q;
  // an abandoned fetch still overwrites the data register, so it must invalidate the tag
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n)
    if (!i_EMU_INITRST_n) begin
      tv_q    <= '0;
      hit_q   <= '0;
      tag_q   <= '0;
      gaddr_q <= '0;
    end else begin
      hit_q <= hit;
      if (grant) gaddr_q <= addr_q[pick];
      if (ack) begin
        tv_q[gnt_q]  <= live_d;
        tag_q[gnt_q] <= gaddr_q;
      end
    end
`else
  assign hit  = '0;
  assign fast = '0;
`endif
  assign o_PROGROM_DATA = pdata_q;
  assign o_PROGROM_RDY  = rdy_q[0];
  assign o_DATAROM_DATA = ddata_q;
  assign o_DATAROM_RDY  = rdy_q[1];
  assign o_SNDROM_DATA  = sdata_q;
  assign o_SNDROM_RDY   = rdy_q[2];
  assign o_MEM_ADDR     = mem_addr_q;
  assign o_MEM_RD       = mem_rd_q;
endmodule

// File: tb/tb_salamander_romport_arbiter.sv
// tb_salamander_romport_arbiter: scenario tasks with an address scoreboard checked at each memory strobe.
module tb_salamander_romport_arbiter;
  logic clk = 0, rst_n = 0;
  logic [15:0] p_addr = '0, p_data;
  logic [16:0] d_addr = '0;
  logic [15:0] d_data;
  logic [14:0] s_addr = '0;
  logic [7:0] s_data;
  logic p_rq = 0, d_rq = 0, s_rq = 0, p_rdy, d_rdy, s_rdy;
  logic [18:0] mem_addr;
  logic mem_rd, ack = 0, rd_prev = 0;
  logic [15:0] mem_data = '0;
  int n_chk = 0, n_fail = 0, cyc = 0, nstrb = 0;
  logic [18:0] exp_q[$];

  salamander_romport_arbiter dut (
    .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n),
    .i_PROGROM_ADDR(p_addr), .i_PROGROM_RDRQ(p_rq), .o_PROGROM_DATA(p_data), .o_PROGROM_RDY(p_rdy),
    .i_DATAROM_ADDR(d_addr), .i_DATAROM_RDRQ(d_rq), .o_DATAROM_DATA(d_data), .o_DATAROM_RDY(d_rdy),
    .i_SNDROM_ADDR(s_addr), .i_SNDROM_RDRQ(s_rq), .o_SNDROM_DATA(s_data), .o_SNDROM_RDY(s_rdy),
    .o_MEM_ADDR(mem_addr), .o_MEM_RD(mem_rd), .i_MEM_ACK(ack), .i_MEM_DATA(mem_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (mem_rd && !rd_prev) nstrb++;
    rd_prev = mem_rd;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_strobe();
    int n = 0;
    logic [18:0] e;
    while (!mem_rd && n < 50) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.size() != 0 ? exp_q.pop_front() : 19'h7FFFF;
    n_chk++;
    if (mem_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL strobe_timeout: mem_rd=%b required 1", mem_rd);
    end
    n_chk++;
    if (mem_addr !== e) begin
      n_fail++;
      $display("FAIL mem_addr: got %h required %h", mem_addr, e);
    end
  endtask

  task automatic serve(input int wt, input logic [15:0] d);
    wait_strobe();
    repeat (wt) @(negedge clk);
    ack = 1;
    mem_data = d;
    @(negedge clk);
    ack = 0;
    mem_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({mem_rd, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: got rd=%b addr=%h required 0/0", mem_rd, mem_addr);
    end
    n_chk++;
    if ({p_data, d_data, s_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h required 0", p_data, d_data, s_data);
    end
    n_chk++;
    if ({p_rdy, d_rdy, s_rdy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b%b%b required 000", p_rdy, d_rdy, s_rdy);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single_prog();
    p_addr = 16'h1234;
    p_rq = 1;
    exp_q.push_back(19'h01234);
    serve(1, 16'hBEEF);
    n_chk++;
    if ({p_rdy, p_data, mem_rd} !== {1'b1, 16'hBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL prog_fetch: got rdy=%b data=%h rd=%b required 1 beef 0", p_rdy, p_data, mem_rd);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (p_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL prog_rdy_hold: got %b required 1", p_rdy);
    end
    p_rq = 0;
    @(negedge clk);
    n_chk++;
    if ({p_rdy, p_data} !== {1'b0, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL prog_rdy_fall: got rdy=%b data=%h required 0 beef", p_rdy, p_data);
    end
  endtask

  task automatic test_sound_bytes();
    int c0;
    s_addr = 15'h0101;
    s_rq = 1;
    c0 = cyc;
    exp_q.push_back(19'h40080);
    serve(0, 16'hA55A);
    n_chk++;
    if ({s_rdy, s_data} !== {1'b1, 8'h5A}) begin
      n_fail++;
      $display("FAIL snd_low_byte: got rdy=%b data=%h required 1 5a", s_rdy, s_data);
    end
    n_chk++;
    if (cyc - c0 != 3) begin
      n_fail++;
      $display("FAIL min_latency: got %0d edges required 3", cyc - c0);
    end
    s_rq = 0;
    @(negedge clk);
    s_addr = 15'h0100;
    s_rq = 1;
    exp_q.push_back(19'h40080);
    serve(0, 16'hA55A);
    n_chk++;
    if ({s_rdy, s_data} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL snd_high_byte: got rdy=%b data=%h required 1 a5", s_rdy, s_data);
    end
    s_rq = 0;
    @(negedge clk);
  endtask

  task automatic test_ack_idle();
    ack = 1;
    mem_data = 16'hFFFF;
    @(negedge clk);
    ack = 0;
    mem_data = '0;
    @(negedge clk);
    n_chk++;
    if ({mem_rd, p_data, d_data, s_data, p_rdy, d_rdy, s_rdy} !== {1'b0, 16'hBEEF, 16'h0, 8'hA5, 3'b000}) begin
      n_fail++;
      $display("FAIL ack_idle: got rd=%b %h %h %h rdy=%b%b%b required 0 beef 0000 a5 000",
               mem_rd, p_data, d_data, s_data, p_rdy, d_rdy, s_rdy);
    end
  endtask

  task automatic test_round_robin();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    p_addr = 16'h0AAA;
    d_addr = 17'h00555;
    s_addr = 15'h1002;
    {p_rq, d_rq, s_rq} = 3'b111;
    exp_q.push_back(19'h00AAA);
    exp_q.push_back(19'h20555);
    exp_q.push_back(19'h40801);
    serve(0, 16'h1111);
    serve(2, 16'h2222);
    serve(0, 16'h3333);
    n_chk++;
    if ({p_data, d_data, s_data, p_rdy, d_rdy, s_rdy} !== {16'h1111, 16'h2222, 8'h33, 3'b111}) begin
      n_fail++;
      $display("FAIL rr_first: got %h %h %h rdy=%b%b%b required 1111 2222 33 111",
               p_data, d_data, s_data, p_rdy, d_rdy, s_rdy);
    end
    {p_rq, d_rq, s_rq} = 3'b000;
    @(negedge clk);
    n_chk++;
    if ({p_rdy, d_rdy, s_rdy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rr_rdy_fall: got %b%b%b required 000", p_rdy, d_rdy, s_rdy);
    end
    d_addr = 17'h10005;
    d_rq = 1;
    exp_q.push_back(19'h30005);
    serve(0, 16'h4444);
    d_rq = 0;
    @(negedge clk);
    p_addr = 16'hFFFF;
    s_addr = 15'h7FFF;
    {p_rq, d_rq, s_rq} = 3'b111;
    exp_q.push_back(19'h43FFF);
    exp_q.push_back(19'h0FFFF);
    exp_q.push_back(19'h30005);
    serve(0, 16'h5A5A);
    serve(0, 16'h6B6B);
    serve(0, 16'h7C7C);
    n_chk++;
    if ({p_data, d_data, s_data} !== {16'h6B6B, 16'h7C7C, 8'h5A}) begin
      n_fail++;
      $display("FAIL rr_second: got %h %h %h required 6b6b 7c7c 5a", p_data, d_data, s_data);
    end
    {p_rq, d_rq, s_rq} = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_drop_busy();
    d_addr = 17'h00123;
    d_rq = 1;
    exp_q.push_back(19'h20123);
    wait_strobe();
    d_rq = 0;
    p_addr = 16'h0042;
    p_rq = 1;
    exp_q.push_back(19'h00042);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({mem_rd, mem_addr} !== {1'b1, 19'h20123}) begin
      n_fail++;
      $display("FAIL drop_hold: got rd=%b addr=%h required 1 20123", mem_rd, mem_addr);
    end
    ack = 1;
    mem_data = 16'h1357;
    @(negedge clk);
    ack = 0;
    mem_data = '0;
    n_chk++;
    if ({d_rdy, d_data, mem_rd} !== {1'b0, 16'h1357, 1'b0}) begin
      n_fail++;
      $display("FAIL drop_done: got rdy=%b data=%h rd=%b required 0 1357 0", d_rdy, d_data, mem_rd);
    end
    @(negedge clk);
    n_chk++;
    if (mem_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_next_issue: got rd=%b required 1", mem_rd);
    end
    serve(0, 16'h2468);
    n_chk++;
    if ({p_rdy, p_data, d_rdy} !== {1'b1, 16'h2468, 1'b0}) begin
      n_fail++;
      $display("FAIL drop_next_data: got prdy=%b data=%h drdy=%b required 1 2468 0", p_rdy, p_data, d_rdy);
    end
    p_rq = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    s_addr = 15'h0200;
    s_rq = 1;
    exp_q.push_back(19'h40100);
    serve(0, 16'h9A9A);
    p_addr = 16'h0777;
    p_rq = 1;
    exp_q.push_back(19'h00777);
    wait_strobe();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({mem_rd, p_rdy, d_rdy, s_rdy, p_data, d_data, s_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_busy: got rd=%b rdy=%b%b%b data=%h %h %h required all 0",
               mem_rd, p_rdy, d_rdy, s_rdy, p_data, d_data, s_data);
    end
    p_rq = 0;
    s_rq = 0;
    @(negedge clk);
    rst_n = 1;
    ack = 1;
    mem_data = 16'hDEAD;
    @(negedge clk);
    ack = 0;
    mem_data = '0;
    @(negedge clk);
    n_chk++;
    if ({mem_rd, p_rdy, d_rdy, s_rdy, p_data, d_data, s_data} !== '0) begin
      n_fail++;
      $display("FAIL late_ack: got rd=%b rdy=%b%b%b data=%h %h %h required all 0",
               mem_rd, p_rdy, d_rdy, s_rdy, p_data, d_data, s_data);
    end
  endtask

  task automatic test_repeat();
    int s0;
    s0 = nstrb;
    p_addr = 16'h0010;
    p_rq = 1;
    exp_q.push_back(19'h00010);
    serve(0, 16'h1111);
    p_rq = 0;
    @(negedge clk);
    p_rq = 1;
`ifdef SALAMANDER_ROMARB_CACHE_EN
    repeat (2) @(negedge clk);
    n_chk++;
    if ({p_rdy, p_data, mem_rd} !== {1'b1, 16'h1111, 1'b0} || nstrb - s0 != 1) begin
      n_fail++;
      $display("FAIL cache_hit: got rdy=%b data=%h strobes=%0d required 1 1111 1", p_rdy, p_data, nstrb - s0);
    end
`else
    exp_q.push_back(19'h00010);
    serve(0, 16'h2222);
    n_chk++;
    if ({p_rdy, p_data} !== {1'b1, 16'h2222} || nstrb - s0 != 2) begin
      n_fail++;
      $display("FAIL repeat_fetch: got rdy=%b data=%h strobes=%0d required 1 2222 2", p_rdy, p_data, nstrb - s0);
    end
`endif
    p_rq = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_prog();
    test_sound_bytes();
    test_ack_idle();
    test_round_robin();
    test_drop_busy();
    test_reset_busy();
    test_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/salamander_romport_arbiter.md
# salamander_romport_arbiter

Shares a single external ROM read port (SDRAM/BRAM bridge) between three ROM requesters: main 68000 program ROM, main 68000 data ROM, and sound Z80 program ROM. Sits between the CPU address decoders and the emulator memory controller. It round-robin arbitrates level requests, maps each requester into one linear word space, latches returned data per requester and raises a per-requester ready flag for DTACK/WAIT stretching.

## Interface
- `PROG_BASE`, default 19'h00000: word base of program ROM region.
- `DATA_BASE`, default 19'h20000: word base of data ROM region.
- `SND_BASE`, default 19'h40000: word base of sound ROM region.
- `i_EMU_MCLK`  in  1  master clock; all state on its rising edge.
- `i_EMU_INITRST_n`  in  1  reset, asynchronous, active-low.
- `i_PROGROM_ADDR`  in  16  program ROM word address.
- `i_PROGROM_RDRQ`  in  1  program ROM read request, level.
- `o_PROGROM_DATA`  out  16  latched program ROM word.
- `o_PROGROM_RDY`  out  1  program data valid for current request.
- `i_DATAROM_ADDR`  in  17  data ROM word address.
- `i_DATAROM_RDRQ`  in  1  data ROM read request, level.
- `o_DATAROM_DATA`  out  16  latched data ROM word.
- `o_DATAROM_RDY`  out  1  data ROM valid.
- `i_SNDROM_ADDR`  in  15  sound ROM byte address.
- `i_SNDROM_RDRQ`  in  1  sound ROM read request, level.
- `o_SNDROM_DATA`  out  8  latched sound ROM byte.
- `o_SNDROM_RDY`  out  1  sound data valid.
- `o_MEM_ADDR`  out  19  external word address.
- `o_MEM_RD`  out  1  external read strobe, held until ack.
- `i_MEM_ACK`  in  1  one-cycle acknowledge; data valid same cycle.
- `i_MEM_DATA`  in  16  external read data.

## Operation
- Request lifecycle per requester: RDRQ rising (low at previous edge, high now) arms a pending flag, capturing address. Pending clears when serviced. RDY set on service, cleared on the edge RDRQ is sampled low. Address changes while RDRQ high are ignored; a new request needs ≥1 sampled-low cycle.
- Address map: prog → PROG_BASE + addr; data → DATA_BASE + addr; sound → SND_BASE + addr[14:1]; all 19-bit, wrap modulo 2^19. Sound byte: addr[0]=0 → [15:8], 1 → [7:0].
- FSM IDLE/BUSY. IDLE: if any pending, grant by round-robin starting at requester after last grant (order prog→data→snd→prog; after reset, prog first); drive o_MEM_ADDR, o_MEM_RD=1, go BUSY. BUSY: hold address and strobe; on i_MEM_ACK latch i_MEM_DATA into granted requester's data register, set its RDY, drop o_MEM_RD, return IDLE.
- RDRQ dropped during BUSY: fetch still completes (strobe never withdrawn); data register updated, RDY not set.
- i_MEM_ACK in IDLE ignored.
- Simultaneous arming of several requesters: all pend; serviced one per fetch in round-robin order.
- Reset: FSM IDLE, o_MEM_RD=0, o_MEM_ADDR=0, all data 0, all RDY 0, pending cleared, last-grant = snd.

## Timing
- RDRQ rising sampled at edge k → o_MEM_RD=1 after edge k+1 (arm at k, issue k+1) if IDLE and granted.
- ACK high at edge m → RDY and data visible after edge m; o_MEM_RD low after m. Back-to-back: next grant issued at edge m+1.
- Minimum request-to-RDY: 3 edges with zero-wait memory (ack first cycle strobe seen).
- RDY falls one edge after RDRQ sampled low.
- Reset asynchronous assert; deassert synchronised externally.

## Configuration
- `SALAMANDER_ROMARB_CACHE_EN`: when defined, each requester keeps a one-entry tag (last serviced address + valid). On arming, if valid and address matches tag, RDY sets at the next edge with no external access and no grant consumed. Tags cleared by reset; tag updated only by completed fetches where RDRQ remained high. When undefined, every request performs an external fetch; no tag logic.

## Test plan
- Single prog fetch: PROGROM_ADDR=16'h1234, RDRQ↑, ACK after 2 strobe cycles with 16'hBEEF → o_MEM_ADDR=19'h01234, PROGROM_DATA=16'hBEEF, RDY high until RDRQ↓.
- Sound byte select: SNDROM_ADDR=15'h0101, mem returns 16'hA55A → o_MEM_ADDR=19'h40080, SNDROM_DATA=8'h5A; addr 15'h0100 → 8'hA5.
- Three simultaneous requests after reset → grants prog, data (19'h2xxxx), snd in order; next simultaneous set after data-last grant → snd, prog, data.
- RDRQ drop mid-BUSY on data request → strobe held to ACK, DATAROM_RDY stays 0; next pending request issues at following edge.
- Reset asserted during BUSY → o_MEM_RD=0, RDY=0, data=0 immediately; late ACK after release ignored.
- Cache on: repeat prog addr 16'h0010 twice → one external strobe, second RDY one edge after arm; cache off → two strobes.
